mem_port_arbiter: RTL and testbench

- Shares one 16B memory port between two blocking caches, requester 0 = icache and requester 1 = dcache, in the multi-core memory system.
- Arbitrates requests round-robin and forwards the granted request unchanged.
- Memory returns responses in order. A small owner FIFO records which requester issued each outstanding request, and each response is steered back to that owner.
- Sits between the cache cache2mem ports and the test/main memory.

---
 rtl/mem_arb_pkg.sv | 27 ++
 rtl/mem_arb_owner_fifo.sv | 55 +++++
 rtl/mem_port_arbiter.sv | 111 +++++++++++
 tb/tb_mem_port_arbiter.sv | 246 ++++++++++++++++++++++++
 4 files changed

// File: rtl/mem_arb_pkg.sv
// Shared types and constants for the two-port memory arbiter.
// Message structs mirror the existing 16B memory request/response layout.
package mem_arb_pkg;

    typedef logic [0:0] owner_id_t;

    localparam owner_id_t ARB_REQ0          = 1'b0;
    localparam owner_id_t ARB_REQ1          = 1'b1;
    localparam int        ARB_DEFAULT_DEPTH = 4;

    typedef struct packed {
        logic [2:0]   type_;
        logic [7:0]   opaque;
        logic [31:0]  addr;
        logic [3:0]   len;
        logic [127:0] data;
    } mem_req_16B_t;

    typedef struct packed {
        logic [2:0]   type_;
        logic [7:0]   opaque;
        logic [1:0]   test;
        logic [3:0]   len;
        logic [127:0] data;
    } mem_resp_16B_t;

endpackage

// File: rtl/mem_arb_owner_fifo.sv
// In-order FIFO of requester IDs, one entry per outstanding memory request.
module mem_arb_owner_fifo
    import mem_arb_pkg::*;
#(
    parameter  int p_max_out = ARB_DEFAULT_DEPTH,
    localparam int PTR_W     = $clog2(p_max_out),
    localparam int CNT_W     = PTR_W + 1
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             push,
    input  owner_id_t        push_id,
    input  logic             pop,
    output owner_id_t        head_id,
    output logic             full,
    output logic             empty,
    output logic [CNT_W-1:0] count
);

    owner_id_t        slots_q [p_max_out];
    logic [PTR_W-1:0] head_q;
    logic [PTR_W-1:0] tail_q;
    logic [CNT_W-1:0] count_q;
    logic             do_push;
    logic             do_pop;

    assign full    = (count_q == CNT_W'(p_max_out));
    assign empty   = (count_q == '0);
    assign count   = count_q;
    assign head_id = slots_q[head_q];
    assign do_push = push & ~full;
    assign do_pop  = pop & ~empty;

    // Depth is a power of two, so pointers wrap by plain overflow.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            head_q  <= '0;
            tail_q  <= '0;
            count_q <= '0;
        end else begin
            if (do_push) tail_q <= tail_q + PTR_W'(1);
            if (do_pop)  head_q <= head_q + PTR_W'(1);
            case ({do_push, do_pop})
                2'b10:   count_q <= count_q + CNT_W'(1);
                2'b01:   count_q <= count_q - CNT_W'(1);
                default: count_q <= count_q;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (do_push) slots_q[tail_q] <= push_id;
    end

endmodule

// File: rtl/mem_port_arbiter.sv
// Round-robin arbiter sharing one 16B memory port between icache (0) and dcache (1).
// Optional MEM_ARB_PERF_CNT_EN adds saturating per-requester grant counters.
module mem_port_arbiter
    import mem_arb_pkg::*;
#(
    parameter int p_max_out = ARB_DEFAULT_DEPTH
) (
    input  logic          clk,
    input  logic          reset,
    input  mem_req_16B_t  req0_msg,
    input  logic          req0_val,
    output logic          req0_rdy,
    input  mem_req_16B_t  req1_msg,
    input  logic          req1_val,
    output logic          req1_rdy,
    output mem_req_16B_t  memreq_msg,
    output logic          memreq_val,
    input  logic          memreq_rdy,
    input  mem_resp_16B_t memresp_msg,
    input  logic          memresp_val,
    output logic          memresp_rdy,
    output mem_resp_16B_t resp0_msg,
    output logic          resp0_val,
    input  logic          resp0_rdy,
    output mem_resp_16B_t resp1_msg,
    output logic          resp1_val,
    input  logic          resp1_rdy
`ifdef MEM_ARB_PERF_CNT_EN
    ,
    output logic [31:0]   num_grants0,
    output logic [31:0]   num_grants1
`endif
);

    localparam int CNT_W = $clog2(p_max_out) + 1;

    if (p_max_out < 2 || (p_max_out & (p_max_out - 1)) != 0) begin : g_bad_depth
        $error("mem_port_arbiter: p_max_out must be a power of two >= 2");
    end

    owner_id_t        prio_q;
    owner_id_t        grant_id;
    owner_id_t        head_id;
    logic             any_val;
    logic             req_fire;
    logic             resp_pop;
    logic             head_rdy;
    logic             fifo_full;
    logic             fifo_empty;
    logic [CNT_W-1:0] fifo_count;

    // Request side: priority holder wins if valid, otherwise the other requester.
    assign any_val    = req0_val | req1_val;
    assign grant_id   = (prio_q == ARB_REQ0) ? (req0_val ? ARB_REQ0 : ARB_REQ1)
                                             : (req1_val ? ARB_REQ1 : ARB_REQ0);
    assign memreq_msg = (grant_id == ARB_REQ1) ? req1_msg : req0_msg;
    assign memreq_val = any_val & ~fifo_full & ~reset;
    assign req0_rdy   = any_val & (grant_id == ARB_REQ0) & memreq_rdy & ~fifo_full & ~reset;
    assign req1_rdy   = any_val & (grant_id == ARB_REQ1) & memreq_rdy & ~fifo_full & ~reset;
    assign req_fire   = memreq_val & memreq_rdy;

    always_ff @(posedge clk or posedge reset) begin
        if (reset)         prio_q <= ARB_REQ0;
        else if (req_fire) prio_q <= ~grant_id;
    end

    // Response side: memory answers in order, so the FIFO head names the owner.
    assign head_rdy    = (head_id == ARB_REQ1) ? resp1_rdy : resp0_rdy;
    assign memresp_rdy = ~fifo_empty & head_rdy & ~reset;
    assign resp0_val   = memresp_val & ~fifo_empty & (head_id == ARB_REQ0) & ~reset;
    assign resp1_val   = memresp_val & ~fifo_empty & (head_id == ARB_REQ1) & ~reset;
    assign resp0_msg   = memresp_msg;
    assign resp1_msg   = memresp_msg;
    assign resp_pop    = memresp_val & memresp_rdy;

    mem_arb_owner_fifo #(
        .p_max_out (p_max_out)
    ) u_owner_fifo (
        .clk     (clk),
        .reset   (reset),
        .push    (req_fire),
        .push_id (grant_id),
        .pop     (resp_pop),
        .head_id (head_id),
        .full    (fifo_full),
        .empty   (fifo_empty),
        .count   (fifo_count)
    );

    always_comb begin
        assert (fifo_full == (fifo_count == CNT_W'(p_max_out)));
        assert (fifo_empty == (fifo_count == '0));
    end

`ifdef MEM_ARB_PERF_CNT_EN
    function automatic logic [31:0] sat_inc(input logic [31:0] v);
        return (v == 32'hFFFF_FFFF) ? v : v + 32'd1;
    endfunction

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            num_grants0 <= '0;
            num_grants1 <= '0;
        end else if (req_fire) begin
            if (grant_id == ARB_REQ0) num_grants0 <= sat_inc(num_grants0);
            else                      num_grants1 <= sat_inc(num_grants1);
        end
    end
`endif

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Randomized bench for mem_port_arbiter against a queue-based reference model.
module tb_mem_port_arbiter;
    import mem_arb_pkg::*;

    localparam int DEPTH = 4;

    logic          clk = 1'b0;
    logic          reset;
    mem_req_16B_t  req0_msg, req1_msg, memreq_msg;
    logic          req0_val, req0_rdy, req1_val, req1_rdy;
    logic          memreq_val, memreq_rdy;
    mem_resp_16B_t memresp_msg, resp0_msg, resp1_msg;
    logic          memresp_val, memresp_rdy;
    logic          resp0_val, resp0_rdy, resp1_val, resp1_rdy;
`ifdef MEM_ARB_PERF_CNT_EN
    logic [31:0]   num_grants0, num_grants1;
`endif

    int checks   = 0;
    int failures = 0;

    owner_id_t    own_q[$];
    mem_req_16B_t mem_q[$];
    owner_id_t    prio_m;
    int unsigned  ng0_m, ng1_m;

    always #5 clk = ~clk;

    mem_port_arbiter #(.p_max_out(DEPTH)) dut (
        .clk         (clk),
        .reset       (reset),
        .req0_msg    (req0_msg),
        .req0_val    (req0_val),
        .req0_rdy    (req0_rdy),
        .req1_msg    (req1_msg),
        .req1_val    (req1_val),
        .req1_rdy    (req1_rdy),
        .memreq_msg  (memreq_msg),
        .memreq_val  (memreq_val),
        .memreq_rdy  (memreq_rdy),
        .memresp_msg (memresp_msg),
        .memresp_val (memresp_val),
        .memresp_rdy (memresp_rdy),
        .resp0_msg   (resp0_msg),
        .resp0_val   (resp0_val),
        .resp0_rdy   (resp0_rdy),
        .resp1_msg   (resp1_msg),
        .resp1_val   (resp1_val),
        .resp1_rdy   (resp1_rdy)
`ifdef MEM_ARB_PERF_CNT_EN
        ,
        .num_grants0 (num_grants0),
        .num_grants1 (num_grants1)
`endif
    );

    task automatic check_eq(input string tag, input logic [255:0] obs, input logic [255:0] exp);
        checks++;
        if (obs !== exp) begin
            failures++;
            $display("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    function automatic mem_req_16B_t rand_req();
        mem_req_16B_t r;
        r.type_  = 3'($urandom_range(0, 1));
        r.opaque = 8'($urandom);
        r.addr   = $urandom;
        r.len    = 4'($urandom);
        r.data   = {$urandom, $urandom, $urandom, $urandom};
        return r;
    endfunction

    function automatic mem_resp_16B_t make_resp(input mem_req_16B_t q);
        mem_resp_16B_t r;
        r.type_  = q.type_;
        r.opaque = q.opaque;
        r.test   = 2'b00;
        r.len    = q.len;
        r.data   = q.data ^ {4{q.addr}};
        return r;
    endfunction

    task automatic check_quiet(input string where);
        check_eq({where, ".memreq_val"}, memreq_val, 1'b0);
        check_eq({where, ".req0_rdy"}, req0_rdy, 1'b0);
        check_eq({where, ".req1_rdy"}, req1_rdy, 1'b0);
        check_eq({where, ".memresp_rdy"}, memresp_rdy, 1'b0);
        check_eq({where, ".resp0_val"}, resp0_val, 1'b0);
        check_eq({where, ".resp1_val"}, resp1_val, 1'b0);
`ifdef MEM_ARB_PERF_CNT_EN
        check_eq({where, ".num_grants0"}, num_grants0, 32'(ng0_m));
        check_eq({where, ".num_grants1"}, num_grants1, 32'(ng1_m));
`endif
    endtask

    // One clock: drive at posedge+1, compare at posedge+5, advance the model.
    task automatic step(input int pv0, input int pv1, input int pmr, input int prv,
                        input int pr0, input int pr1, input int pstray);
        owner_id_t g, head;
        bit any, full_m, empty_m, e_mv, e_r0, e_r1, e_mrdy, e_v0, e_v1;
        @(posedge clk);
        #1;
        req0_val   = ($urandom_range(0, 99) < pv0);
        req1_val   = ($urandom_range(0, 99) < pv1);
        req0_msg   = rand_req();
        req1_msg   = rand_req();
        memreq_rdy = ($urandom_range(0, 99) < pmr);
        resp0_rdy  = ($urandom_range(0, 99) < pr0);
        resp1_rdy  = ($urandom_range(0, 99) < pr1);
        if (mem_q.size() != 0) begin
            memresp_val = ($urandom_range(0, 99) < prv);
            memresp_msg = make_resp(mem_q[0]);
        end else begin
            memresp_val = ($urandom_range(0, 99) < pstray);
            memresp_msg = make_resp(rand_req());
        end
        #4;
        full_m  = (own_q.size() >= DEPTH);
        empty_m = (own_q.size() == 0);
        any     = req0_val || req1_val;
        if (prio_m == ARB_REQ0) g = req0_val ? ARB_REQ0 : ARB_REQ1;
        else                    g = req1_val ? ARB_REQ1 : ARB_REQ0;
        head   = empty_m ? ARB_REQ0 : own_q[0];
        e_mv   = any && !full_m;
        e_r0   = e_mv && (g == ARB_REQ0) && memreq_rdy;
        e_r1   = e_mv && (g == ARB_REQ1) && memreq_rdy;
        e_mrdy = !empty_m && ((head == ARB_REQ1) ? resp1_rdy : resp0_rdy);
        e_v0   = memresp_val && !empty_m && (head == ARB_REQ0);
        e_v1   = memresp_val && !empty_m && (head == ARB_REQ1);

        check_eq("memreq_val", memreq_val, e_mv);
        if (e_mv) check_eq("memreq_msg", memreq_msg, (g == ARB_REQ1) ? req1_msg : req0_msg);
        check_eq("req0_rdy", req0_rdy, e_r0);
        check_eq("req1_rdy", req1_rdy, e_r1);
        check_eq("memresp_rdy", memresp_rdy, e_mrdy);
        check_eq("resp0_val", resp0_val, e_v0);
        check_eq("resp1_val", resp1_val, e_v1);
        if (e_v0) check_eq("resp0_msg", resp0_msg, memresp_msg);
        if (e_v1) check_eq("resp1_msg", resp1_msg, memresp_msg);
`ifdef MEM_ARB_PERF_CNT_EN
        check_eq("num_grants0", num_grants0, 32'(ng0_m));
        check_eq("num_grants1", num_grants1, 32'(ng1_m));
`endif

        if (e_mv && memreq_rdy) begin
            own_q.push_back(g);
            mem_q.push_back((g == ARB_REQ1) ? req1_msg : req0_msg);
            prio_m = (g == ARB_REQ0) ? ARB_REQ1 : ARB_REQ0;
            if (g == ARB_REQ0) ng0_m++;
            else               ng1_m++;
        end
        if (memresp_val && e_mrdy) begin
            void'(own_q.pop_front());
            void'(mem_q.pop_front());
        end
    endtask

    task automatic drain();
        for (int i = 0; i < 60 && mem_q.size() != 0; i++) step(0, 0, 0, 100, 100, 100, 0);
    endtask

    task automatic async_reset_mid();
        @(posedge clk);
        #2;
        req0_val    = 1'b1;
        req1_val    = 1'b1;
        memreq_rdy  = 1'b1;
        memresp_val = 1'b1;
        resp0_rdy   = 1'b1;
        resp1_rdy   = 1'b1;
        reset       = 1'b1;
        own_q.delete();
        mem_q.delete();
        prio_m = ARB_REQ0;
        ng0_m  = 0;
        ng1_m  = 0;
        #1;
        check_quiet("rst_mid");
        @(posedge clk);
        #1;
        check_quiet("rst_hold");
        req0_val    = 1'b0;
        req1_val    = 1'b0;
        memresp_val = 1'b0;
        #2;
        reset = 1'b0;
    endtask

    initial begin
        #300000;
        $display("FAIL watchdog observed=timeout expected=finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        prio_m      = ARB_REQ0;
        ng0_m       = 0;
        ng1_m       = 0;
        reset       = 1'b1;
        req0_val    = 1'b1;
        req1_val    = 1'b1;
        req0_msg    = rand_req();
        req1_msg    = rand_req();
        memreq_rdy  = 1'b1;
        memresp_val = 1'b1;
        memresp_msg = make_resp(rand_req());
        resp0_rdy   = 1'b1;
        resp1_rdy   = 1'b1;
        #3;
        check_quiet("rst_init");
        req0_val    = 1'b0;
        req1_val    = 1'b0;
        memresp_val = 1'b0;
        #20;
        reset = 1'b0;

        // single requester, memory answering after a short delay
        repeat (8) step(100, 0, 100, 50, 100, 100, 0);
        drain();
        // contention filling the FIFO, then pops while requests keep coming
        repeat (6) step(100, 100, 100, 0, 100, 100, 0);
        repeat (4) step(100, 100, 100, 100, 100, 100, 0);
        drain();
        repeat (20) step(100, 100, 100, 100, 100, 100, 0);
        drain();
        // requester 1 withholding response ready
        repeat (30) step(60, 60, 80, 100, 100, 0, 0);
        drain();
        // stray responses with nothing outstanding
        repeat (10) step(0, 0, 0, 0, 100, 100, 100);
        // random mix
        repeat (3000) step(50, 50, 70, 60, 70, 70, 30);
        drain();
        // reset with three requests outstanding
        repeat (3) step(100, 100, 100, 0, 100, 100, 0);
        async_reset_mid();
        repeat (3) step(100, 100, 100, 0, 100, 100, 100);
        repeat (500) step(50, 50, 70, 60, 70, 70, 30);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
